// File: rtl/riscv_enc_pkg.sv
// Shared encoding constants for the instruction encoder/loader: opcodes, class codes, NOP and fixed funct3 values.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_RTYPE  = 3'd2,
        CLS_ITYPE  = 3'd3,
        CLS_BRANCH = 3'd4
    } instr_class_t;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OP_ITYPE  = 7'b0010011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    localparam logic [2:0]  F3_LW = 3'b010;
    localparam logic [2:0]  F3_SW = 3'b010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: instruction fields -> RV32I word, plus a bad-field flag.
// The flag is only computed when ENC_RANGE_CHECK_EN is defined; otherwise it is constant 0.
module instr_field_packer
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        bad
);

    logic [11:0] i_imm;

    always_comb begin
        word  = NOP_WORD;
        i_imm = imm[11:0];
        case (cls)
            CLS_LOAD:   word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            CLS_STORE:  word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
            CLS_RTYPE:  word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, OP_RTYPE};
            CLS_ITYPE: begin
                // shift-immediate forms carry shamt in imm[4:0] and funct7 in imm[11:5]
                if (funct3 == 3'b001)
                    i_imm[11:5] = '0;
                else if (funct3 == 3'b101)
                    i_imm[11:5] = {1'b0, funct7b5, 5'b0};
                word = {i_imm, rs1, funct3, rd, OP_ITYPE};
            end
            CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            default:    word = NOP_WORD;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    always_comb begin
        bad = 1'b0;
        if (cls > 3'd4)
            bad = 1'b1;
        else if ((cls == CLS_LOAD || cls == CLS_STORE || cls == CLS_ITYPE) && (imm[12] != imm[11]))
            bad = 1'b1;
        else if (cls == CLS_BRANCH && imm[0])
            bad = 1'b1;
    end
`else
    assign bad = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Session FSM that streams packed instructions into imem at an auto-incrementing word address.
// Optional field checking via ENC_RANGE_CHECK_EN (flagged beats are dropped and set sticky err).
module instr_encoder_loader
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_DONE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W+1:0] DEPTH_W2 = (ADDR_W+2)'(DEPTH);

    state_t            state;
    logic              we_q;
    logic              fin_pend;
    logic [31:0]       word;
    logic              bad;
    logic              accept;
    logic              write_next;
    logic [ADDR_W+1:0] occupancy;

    instr_field_packer u_packer (
        .cls      (in_class),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .funct3   (in_funct3),
        .funct7b5 (in_funct7b5),
        .imm      (in_imm),
        .word     (word),
        .bad      (bad)
    );

    assign occupancy  = {1'b0, count} + {{(ADDR_W+1){1'b0}}, we_q};
    assign in_ready   = (state == S_LOAD) && (occupancy < DEPTH_W2) && !fin_pend;
    assign accept     = in_valid && in_ready;
    assign write_next = accept && !bad;

    // Reset squashes a write already staged from the previous edge.
    assign imem_we   = we_q && !rst;
    assign imem_addr = count[ADDR_W-1:0];
    assign busy      = (state == S_LOAD);
    assign full      = (state == S_FULL);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            fin_pend   <= 1'b0;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    we_q <= write_next;
                    if (accept)
                        imem_wdata <= word;
                    if (accept && bad)
                        err <= 1'b1;
                    if (we_q)
                        count <= count + 1'b1;
                    if (finish)
                        fin_pend <= 1'b1;
                    // The in-flight write completes on this edge; leave only once nothing new is staged.
                    if (we_q && count == DEPTH_C - 1'b1)
                        state <= S_FULL;
                    else if ((finish || fin_pend) && !write_next)
                        state <= S_DONE;
                end
                default: begin
                    we_q <= 1'b0;
                    if (start) begin
                        state    <= S_LOAD;
                        count    <= '0;
                        err      <= 1'b0;
                        fin_pend <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed-vector bench for instr_encoder_loader (DEPTH=4); build with ENC_RANGE_CHECK_EN to exercise err.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst, start, finish, in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [12:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy, full, done, err;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] exp_word [0:3];

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .finish      (finish),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_class    (in_class),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_imm      (in_imm),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .count       (count),
        .busy        (busy),
        .full        (full),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                            input logic [12:0] imm);
        in_class    = c;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_imm      = imm;
    endtask

    task automatic set_vec(input int unsigned k);
        case (k)
            0: set_beat(3'd0, 5'd6, 5'd9, 5'd0, 3'd0, 1'b0, -13'sd4);    // lw x6,-4(x9)
            1: set_beat(3'd1, 5'd0, 5'd9, 5'd6, 3'd0, 1'b0, 13'd8);      // sw x6,8(x9)
            2: set_beat(3'd2, 5'd4, 5'd5, 5'd6, 3'b110, 1'b0, 13'd0);    // or x4,x5,x6
            3: set_beat(3'd2, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 13'd0);    // sub x1,x2,x3
            default: set_beat(3'd3, 5'd7, 5'd7, 5'd0, 3'b000, 1'b0, 13'd1);
        endcase
    endtask

    initial begin
        exp_word[0] = 32'hFFC4_A303;
        exp_word[1] = 32'h0064_A423;
        exp_word[2] = 32'h0062_E233;
        exp_word[3] = 32'h4031_00B3;

        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        set_beat(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
        tick; tick;
        check("rst_we",    {31'd0, imem_we},   32'd0);
        check("rst_addr",  {24'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata,         32'd0);
        check("rst_count", {23'd0, count},     32'd0);
        check("rst_flags", {27'd0, in_ready, busy, full, done, err}, 32'd0);
        rst = 1'b0;
        tick;

        // Session A: five beats back-to-back into a 4-deep session
        start = 1'b1; tick; start = 1'b0;
        check("a_busy",  {31'd0, busy},     32'd1);
        check("a_ready", {31'd0, in_ready}, 32'd1);
        set_vec(0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check($sformatf("a_we%0d", i),    {31'd0, imem_we},   32'd1);
            check($sformatf("a_addr%0d", i),  {24'd0, imem_addr}, i);
            check($sformatf("a_wdata%0d", i), imem_wdata,         exp_word[i]);
            check($sformatf("a_count%0d", i), {23'd0, count},     i);
            check($sformatf("a_ready%0d", i), {31'd0, in_ready},  (i < 3) ? 32'd1 : 32'd0);
            set_vec(i + 1);
        end
        tick;
        in_valid = 1'b0;
        check("a_we_stop", {31'd0, imem_we}, 32'd0);
        check("a_full",    {31'd0, full},    32'd1);
        check("a_busy_lo", {31'd0, busy},    32'd0);
        check("a_count4",  {23'd0, count},   32'd4);
        check("a_ready_lo",{31'd0, in_ready},32'd0);

        // Session B: branch, then srai with finish on the same accepting edge
        start = 1'b1; tick; start = 1'b0;
        check("b_count0", {23'd0, count}, 32'd0);
        check("b_busy",   {31'd0, busy},  32'd1);
        set_beat(3'd4, 5'd0, 5'd4, 5'd4, 3'b000, 1'b0, -13'sd20);
        in_valid = 1'b1;
        tick;
        // B-format of -20: imm[12]=1, imm[10:5]=3F, imm[4:1]=0110, imm[11]=1
        check("b_beq_we",    {31'd0, imem_we},   32'd1);
        check("b_beq_wdata", imem_wdata,         32'hFE42_06E3);
        check("b_beq_addr",  {24'd0, imem_addr}, 32'd0);
        set_beat(3'd3, 5'd1, 5'd1, 5'd0, 3'b101, 1'b1, 13'd3);
        finish = 1'b1;
        tick;
        in_valid = 1'b0; finish = 1'b0;
        check("b_srai_we",    {31'd0, imem_we},   32'd1);
        check("b_srai_wdata", imem_wdata,         32'h4030_D093);
        check("b_srai_addr",  {24'd0, imem_addr}, 32'd1);
        check("b_fin_ready",  {31'd0, in_ready},  32'd0);
        tick;
        check("b_done",     {31'd0, done},     32'd1);
        check("b_done_we",  {31'd0, imem_we},  32'd0);
        check("b_done_rdy", {31'd0, in_ready}, 32'd0);
        check("b_count2",   {23'd0, count},    32'd2);
        start = 1'b1; tick; start = 1'b0;
        check("c_count0", {23'd0, count}, 32'd0);
        check("c_busy",   {31'd0, busy},  32'd1);
        check("c_done0",  {31'd0, done},  32'd0);

        // Session C: out-of-range fields
        set_beat(3'd5, 5'd3, 5'd3, 5'd3, 3'd0, 1'b0, 13'd0);
        in_valid = 1'b1;
        tick;
        set_beat(3'd3, 5'd1, 5'd1, 5'd0, 3'b000, 1'b0, 13'd3000);
`ifdef ENC_RANGE_CHECK_EN
        check("c_cls_we",  {31'd0, imem_we}, 32'd0);
        check("c_cls_err", {31'd0, err},     32'd1);
        tick;
        in_valid = 1'b0;
        check("c_imm_we",  {31'd0, imem_we}, 32'd0);
        check("c_imm_err", {31'd0, err},     32'd1);
        tick;
        check("c_count",   {23'd0, count},   32'd0);
`else
        check("c_nop_we",    {31'd0, imem_we}, 32'd1);
        check("c_nop_wdata", imem_wdata,       32'h0000_0013);
        tick;
        in_valid = 1'b0;
        check("c_trunc_we",    {31'd0, imem_we}, 32'd1);
        check("c_trunc_wdata", imem_wdata,       32'hBB80_8093);
        tick;
        check("c_count",   {23'd0, count},   32'd2);
        check("c_err0",    {31'd0, err},     32'd0);
`endif

        // Reset the cycle after an accepted beat: staged write must not appear
        set_beat(3'd0, 5'd6, 5'd9, 5'd0, 3'd0, 1'b0, -13'sd4);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("d_rst_we", {31'd0, imem_we}, 32'd0);
        tick;
        rst = 1'b0;
        check("d_rst_we2",   {31'd0, imem_we}, 32'd0);
        check("d_rst_count", {23'd0, count},   32'd0);
        check("d_rst_busy",  {31'd0, busy},    32'd0);
        check("d_rst_err",   {31'd0, err},     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
